// File: rtl/icache_port_arbiter.sv
// Shares the single icache request port between instruction fetch and CACHE maintenance ops,
// routing responses in order and dropping flushed fetches. Optional counters: ICACHE_ARB_PERF_EN.
module icache_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int IDX_W           = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             fetch_req,
  input  logic [IDX_W-1:0] fetch_index,
  input  logic [3:0]       fetch_offset,
  output logic             fetch_addr_ok,
  output logic             fetch_data_ok,
  output logic [31:0]      fetch_rdata,
  input  logic             fetch_cancel,
  input  logic             cop_req,
  input  logic [1:0]       cop_op,
  input  logic [IDX_W-1:0] cop_index,
  input  logic [19:0]      cop_tag,
  output logic             cop_done,
  output logic             icache_req,
  output logic [1:0]       icache_op,
  output logic [IDX_W-1:0] icache_index,
  output logic [3:0]       icache_offset,
  output logic [19:0]      icache_tag,
  input  logic             icache_addr_ok,
  input  logic             icache_data_ok,
  input  logic [31:0]      icache_rdata,
  output logic [2:0]       fsm_state
`ifdef ICACHE_ARB_PERF_EN
  ,
  output logic [31:0]      perf_fetch_stall,
  output logic [31:0]      perf_drop_cnt
`endif
);

  // Handshake: a request transfers on a cycle where icache_req && icache_addr_ok;
  // icache_req and its fields stay stable until then (FLOCK/COP hold them).
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FLOCK = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] COP   = 3'd3;
  localparam logic [2:0] CWAIT = 3'd4;

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [2:0]       state, state_nxt;
  logic             req_raw;
  logic             is_cop;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             fifo_src [MAX_OUTSTANDING];
  logic             fifo_can [MAX_OUTSTANDING];
  logic             full, push, pop, head_src, head_can, drop;

  assign fsm_state = state;
  assign full      = (count == CNT_W'(MAX_OUTSTANDING));
  assign is_cop    = (state == COP);

  always_comb begin
    state_nxt = state;
    req_raw   = 1'b0;
    case (state)
      IDLE: begin
        if (cop_req) begin
          state_nxt = DRAIN;
        end else begin
          req_raw = fetch_req && !full;
          if (req_raw && !icache_addr_ok) state_nxt = FLOCK;
        end
      end
      FLOCK: begin
        req_raw = fetch_req && !full;
        if (!fetch_req || (req_raw && icache_addr_ok)) state_nxt = IDLE;
      end
      DRAIN: begin
        if (count == '0 || (count == CNT_W'(1) && pop)) state_nxt = COP;
      end
      COP: begin
        req_raw = !full;
        if (req_raw && icache_addr_ok) state_nxt = CWAIT;
      end
      CWAIT: begin
        if (cop_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Nothing is offered to the icache while held in reset, so no response can be orphaned.
  assign icache_req    = req_raw && resetn;
  assign icache_op     = (icache_req && is_cop) ? cop_op : 2'd0;
  assign icache_index  = !icache_req ? '0 : (is_cop ? cop_index : fetch_index);
  assign icache_offset = (icache_req && !is_cop) ? fetch_offset : 4'd0;
  assign icache_tag    = (icache_req && is_cop) ? cop_tag : 20'd0;

  assign fetch_addr_ok = icache_addr_ok && icache_req && (state == IDLE || state == FLOCK);
  assign fetch_rdata   = icache_rdata;

  assign push     = icache_req && icache_addr_ok;
  assign pop      = resetn && icache_data_ok && (count != '0);
  assign head_src = fifo_src[rd_ptr];
  assign head_can = fifo_can[rd_ptr];

  assign fetch_data_ok = pop && !head_src && !head_can && !fetch_cancel;
  assign drop          = pop && !head_src && (head_can || fetch_cancel);
  assign cop_done      = pop && head_src && (state == CWAIT);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_src[i] <= 1'b0;
        fifo_can[i] <= 1'b0;
      end
    end else begin
      state <= state_nxt;
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (push) wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + PTR_W'(1);
      // A flush marks every fetch entry, including one entering this cycle; cop entries stay live.
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (push && wr_ptr == PTR_W'(i)) begin
          fifo_src[i] <= is_cop;
          fifo_can[i] <= fetch_cancel && !is_cop;
        end else if (fetch_cancel && !fifo_src[i]) begin
          fifo_can[i] <= 1'b1;
        end
      end
    end
  end

`ifdef ICACHE_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_fetch_stall <= 32'd0;
      perf_drop_cnt    <= 32'd0;
    end else begin
      if (fetch_req && !fetch_addr_ok) perf_fetch_stall <= perf_fetch_stall + 32'd1;
      if (drop)                        perf_drop_cnt    <= perf_drop_cnt + 32'd1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

`ifndef SYNTHESIS
  // A response with nothing in flight is a protocol error upstream; it is ignored.
  stray_data_ok: assert property (@(posedge clk) disable iff (!resetn)
    icache_data_ok |-> count != '0);
`endif

endmodule

// File: tb/tb_icache_port_arbiter.sv
// Directed self-checking bench for icache_port_arbiter: fetch streaming, back-pressure,
// flush drops, cache-op draining, fetch lock and mid-op reset.
module tb_icache_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        fetch_req;
  logic [7:0]  fetch_index;
  logic [3:0]  fetch_offset;
  logic        fetch_addr_ok, fetch_data_ok;
  logic [31:0] fetch_rdata;
  logic        fetch_cancel;
  logic        cop_req;
  logic [1:0]  cop_op;
  logic [7:0]  cop_index;
  logic [19:0] cop_tag;
  logic        cop_done;
  logic        icache_req;
  logic [1:0]  icache_op;
  logic [7:0]  icache_index;
  logic [3:0]  icache_offset;
  logic [19:0] icache_tag;
  logic        icache_addr_ok, icache_data_ok;
  logic [31:0] icache_rdata;
  logic [2:0]  fsm_state;
`ifdef ICACHE_ARB_PERF_EN
  logic [31:0] perf_fetch_stall, perf_drop_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd_tab [4] = '{32'h24020001, 32'h8c430004, 32'h00000000, 32'hffffffff};

  icache_port_arbiter dut (
    .clk(clk), .resetn(resetn),
    .fetch_req(fetch_req), .fetch_index(fetch_index), .fetch_offset(fetch_offset),
    .fetch_addr_ok(fetch_addr_ok), .fetch_data_ok(fetch_data_ok), .fetch_rdata(fetch_rdata),
    .fetch_cancel(fetch_cancel),
    .cop_req(cop_req), .cop_op(cop_op), .cop_index(cop_index), .cop_tag(cop_tag),
    .cop_done(cop_done),
    .icache_req(icache_req), .icache_op(icache_op), .icache_index(icache_index),
    .icache_offset(icache_offset), .icache_tag(icache_tag),
    .icache_addr_ok(icache_addr_ok), .icache_data_ok(icache_data_ok),
    .icache_rdata(icache_rdata), .fsm_state(fsm_state)
`ifdef ICACHE_ARB_PERF_EN
    , .perf_fetch_stall(perf_fetch_stall), .perf_drop_cnt(perf_drop_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fr, input logic [7:0] fi, input logic ao,
                       input logic dok, input logic [31:0] rd, input logic can);
    fetch_req      = fr;
    fetch_index    = fi;
    icache_addr_ok = ao;
    icache_data_ok = dok;
    icache_rdata   = rd;
    fetch_cancel   = can;
    #2;
  endtask

  initial begin
    resetn = 1'b0; fetch_offset = 4'h4;
    cop_req = 1'b0; cop_op = 2'd0; cop_index = 8'h00; cop_tag = 20'h0;
    drive(1'b1, 8'h77, 1'b1, 1'b0, 32'h24020001, 1'b0);
    tick(); tick();

    // reset state: outputs quiet even with a fetch pending, rdata passes through
    drive(1'b1, 8'h77, 1'b1, 1'b0, 32'h24020001, 1'b0);
    check("rst_req", icache_req, 0);
    check("rst_addr_ok", fetch_addr_ok, 0);
    check("rst_data_ok", fetch_data_ok, 0);
    check("rst_cop_done", cop_done, 0);
    check("rst_index", icache_index, 0);
    check("rst_state", fsm_state, 0);
    check("rst_rdata", fetch_rdata, 32'h24020001);
    resetn = 1'b1;

    // back-to-back fetch, response one cycle after accept
    drive(1'b1, 8'h10, 1'b1, 1'b0, 32'h0, 1'b0);
    check("b2b_req0", icache_req, 1);
    check("b2b_aok0", fetch_addr_ok, 1);
    check("b2b_idx0", icache_index, 8'h10);
    check("b2b_off0", icache_offset, 4'h4);
    check("b2b_op0", icache_op, 0);
    check("b2b_tag0", icache_tag, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(rd_tab[i]);
      drive(1'b1, 8'h11 + 8'(i), 1'b1, 1'b1, rd_tab[i], 1'b0);
      check("b2b_aok", fetch_addr_ok, 1);
      check("b2b_dok", fetch_data_ok, 1);
      check("b2b_rdata", fetch_rdata, exp_q.pop_front());
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 32'h12345678, 1'b0);
    check("b2b_last_dok", fetch_data_ok, 1);
    check("b2b_last_req", icache_req, 0);
    tick();

    // back-pressure: two accepts fill the FIFO, third waits for a response
    drive(1'b1, 8'h20, 1'b1, 1'b0, 32'h0, 1'b0);
    check("bp_aok1", fetch_addr_ok, 1);
    tick();
    drive(1'b1, 8'h21, 1'b1, 1'b0, 32'h0, 1'b0);
    check("bp_aok2", fetch_addr_ok, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h22, 1'b1, 1'b0, 32'h0, 1'b0);
      check("bp_full_req", icache_req, 0);
      check("bp_full_aok", fetch_addr_ok, 0);
      tick();
    end
    drive(1'b1, 8'h22, 1'b1, 1'b1, 32'hcafe0001, 1'b0);
    check("bp_pop_dok", fetch_data_ok, 1);
    check("bp_pop_req", icache_req, 0);
    tick();
    drive(1'b1, 8'h22, 1'b1, 1'b0, 32'h0, 1'b0);
    check("bp_aok3", fetch_addr_ok, 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1, 32'hcafe0002, 1'b0);
      check("bp_drain_dok", fetch_data_ok, 1);
      tick();
    end

    // flush: two in flight, cancel, both responses dropped
    drive(1'b1, 8'h30, 1'b1, 1'b0, 32'h0, 1'b0); check("cx_aok1", fetch_addr_ok, 1); tick();
    drive(1'b1, 8'h31, 1'b1, 1'b0, 32'h0, 1'b0); check("cx_aok2", fetch_addr_ok, 1); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1); check("cx_req", icache_req, 0); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 32'h1111, 1'b0); check("cx_drop1", fetch_data_ok, 0); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 32'h2222, 1'b0); check("cx_drop2", fetch_data_ok, 0); tick();
    // FIFO must be empty: exactly two more accepts before full
    drive(1'b1, 8'h32, 1'b1, 1'b0, 32'h0, 1'b0); check("cx_re_aok1", fetch_addr_ok, 1); tick();
    drive(1'b1, 8'h33, 1'b1, 1'b0, 32'h0, 1'b0); check("cx_re_aok2", fetch_addr_ok, 1); tick();
    drive(1'b1, 8'h34, 1'b1, 1'b0, 32'h0, 1'b0); check("cx_re_full", icache_req, 0); tick();
    // same-cycle cancel drops the head response and marks the one behind it
    drive(1'b0, 8'h00, 1'b0, 1'b1, 32'h3333, 1'b1); check("cx_same_drop", fetch_data_ok, 0); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 32'h4444, 1'b0); check("cx_tail_drop", fetch_data_ok, 0); tick();
`ifdef ICACHE_ARB_PERF_EN
    check("perf_drop", perf_drop_cnt, 4);
`endif

    // cache op with one fetch in flight: drain, issue, wait, done
    cop_op = 2'd1; cop_index = 8'h5a; cop_tag = 20'habcde;
    drive(1'b1, 8'h40, 1'b1, 1'b0, 32'h0, 1'b0); check("cop_f_aok", fetch_addr_ok, 1); tick();
    cop_req = 1'b1;
    drive(1'b1, 8'h41, 1'b1, 1'b0, 32'h0, 1'b0);
    check("cop_idle_req", icache_req, 0);
    check("cop_idle_aok", fetch_addr_ok, 0);
    tick();
    drive(1'b1, 8'h41, 1'b1, 1'b0, 32'h0, 1'b0);
    check("cop_drain_state", fsm_state, 3'd2);
    check("cop_drain_req", icache_req, 0);
    tick();
    drive(1'b1, 8'h41, 1'b1, 1'b1, 32'h5555, 1'b0);
    check("cop_drain_dok", fetch_data_ok, 1);
    check("cop_drain_aok", fetch_addr_ok, 0);
    check("cop_drain_done", cop_done, 0);
    tick();
    drive(1'b1, 8'h41, 1'b1, 1'b0, 32'h0, 1'b0);
    check("cop_issue_req", icache_req, 1);
    check("cop_issue_op", icache_op, 1);
    check("cop_issue_idx", icache_index, 8'h5a);
    check("cop_issue_tag", icache_tag, 20'habcde);
    check("cop_issue_off", icache_offset, 0);
    check("cop_issue_faok", fetch_addr_ok, 0);
    tick();
    drive(1'b1, 8'h41, 1'b1, 1'b0, 32'h0, 1'b0);
    check("cop_wait_req", icache_req, 0);
    check("cop_wait_done", cop_done, 0);
    tick();
    drive(1'b1, 8'h41, 1'b1, 1'b1, 32'h6666, 1'b0);
    check("cop_done", cop_done, 1);
    check("cop_done_fdok", fetch_data_ok, 0);
    check("cop_done_faok", fetch_addr_ok, 0);
    tick();
    cop_req = 1'b0;
    drive(1'b1, 8'h41, 1'b1, 1'b0, 32'h0, 1'b0);
    check("cop_after_aok", fetch_addr_ok, 1);
    check("cop_after_done", cop_done, 0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 32'h7777, 1'b0); check("cop_after_dok", fetch_data_ok, 1); tick();

    // fetch lock: fetch stalled by addr_ok=0 keeps the port while cop_req rises
    cop_op = 2'd3; cop_index = 8'h33; cop_tag = 20'h12345;
    drive(1'b1, 8'h50, 1'b0, 1'b0, 32'h0, 1'b0);
    check("fl_req", icache_req, 1);
    check("fl_aok", fetch_addr_ok, 0);
    tick();
    cop_req = 1'b1;
    drive(1'b1, 8'h50, 1'b0, 1'b0, 32'h0, 1'b0);
    check("fl_state", fsm_state, 3'd1);
    check("fl_hold_req", icache_req, 1);
    check("fl_hold_op", icache_op, 0);
    tick();
    drive(1'b1, 8'h50, 1'b0, 1'b0, 32'h0, 1'b0); check("fl_hold_aok", fetch_addr_ok, 0); tick();
    drive(1'b1, 8'h50, 1'b1, 1'b0, 32'h0, 1'b0);
    check("fl_accept", fetch_addr_ok, 1);
    check("fl_accept_idx", icache_index, 8'h50);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0); check("fl_to_drain_req", icache_req, 0); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 32'h8888, 1'b0);
    check("fl_drain_state", fsm_state, 3'd2);
    check("fl_drain_dok", fetch_data_ok, 1);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0);
    check("fl_cop_op", icache_op, 3);
    check("fl_cop_idx", icache_index, 8'h33);
    check("fl_cop_tag", icache_tag, 20'h12345);
    tick();

    // reset during CWAIT: state cleared, no cop_done, stray response in reset ignored
    resetn = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
    check("mr_state_before", fsm_state, 3'd4);
    tick();
    cop_req = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b1, 32'h9999, 1'b0);
    check("mr_state", fsm_state, 0);
    check("mr_cop_done", cop_done, 0);
    check("mr_fdok", fetch_data_ok, 0);
    check("mr_req", icache_req, 0);
    check("mr_op", icache_op, 0);
    tick();
    resetn = 1'b1;
    drive(1'b1, 8'h60, 1'b1, 1'b0, 32'h0, 1'b0); check("mr_aok1", fetch_addr_ok, 1); tick();
    drive(1'b1, 8'h61, 1'b1, 1'b0, 32'h0, 1'b0); check("mr_aok2", fetch_addr_ok, 1); tick();
    drive(1'b1, 8'h62, 1'b1, 1'b0, 32'h0, 1'b0); check("mr_full", icache_req, 0); tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1, 32'habc0 + 32'(i), 1'b0);
      check("mr_drain_dok", fetch_data_ok, 1);
      check("mr_drain_done", cop_done, 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/icache_port_arbiter.md
Name: icache_port_arbiter

Overview:
- Owns the single icache request port and shares it between instruction fetch (pre-IF) and CACHE-instruction maintenance ops from MEM.
- Tracks in-flight requests in order, so each data_ok is routed to its source.
- Drops fetch responses made stale by pipeline or BPU flush.
- Drains outstanding fetches before issuing a cache op, so maintenance is never reordered with fetches.

Parameters:
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered icache requests (power of 2, ≥1).
- IDX_W, 8: icache index width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- fetch_req  in  1  fetch address request
- fetch_index  in  IDX_W  fetch index
- fetch_offset  in  4  fetch offset
- fetch_addr_ok  out  1  fetch request accepted this cycle
- fetch_data_ok  out  1  fetch data valid (non-cancelled only)
- fetch_rdata  out  32  fetch data (icache_rdata passthrough)
- fetch_cancel  in  1  flush: pipeline flush OR bpu_flush
- cop_req  in  1  cache-op request (level, held until cop_done)
- cop_op  in  2  1=index invalidate, 2=hit invalidate, 3=index store tag
- cop_index  in  IDX_W  cache-op index
- cop_tag  in  20  cache-op tag / hit address
- cop_done  out  1  one-cycle pulse when cache op completes
- icache_req  out  1  request to icache
- icache_op  out  2  0=read, else cache-op code
- icache_index  out  IDX_W  index to icache
- icache_offset  out  4  offset to icache
- icache_tag  out  20  tag (zero for reads)
- icache_addr_ok  in  1  icache accepted request
- icache_data_ok  in  1  icache response
- icache_rdata  in  32  icache read data

Behaviour:
- Reset (resetn=0 at clk edge): state=IDLE, FIFO empty, outstanding count=0. All outputs 0; fetch_rdata passes through.
- In-flight FIFO: depth MAX_OUTSTANDING. Entry = {src (0 fetch / 1 cop), cancelled}.
  - Push on icache_req && icache_addr_ok.
  - Pop on icache_data_ok.
  - Push and pop in the same cycle leave the count unchanged.
  - Full: icache_req forced 0, so no accept.
- FSM:
  - IDLE:
    - cop_req=1 → DRAIN. Cop has priority; the fetch is not granted this cycle.
    - Else icache_req=fetch_req && !full, with op=0 and fetch fields.
    - A fetch request that is presented but not accepted (addr_ok=0) → FLOCK.
  - FLOCK: fetch keeps the grant. Stay until addr_ok or fetch_req drops, then → IDLE. cop_req is ignored in FLOCK.
  - DRAIN:
    - icache_req=0; fetch_addr_ok=0.
    - Leave when count==0, or count==1 with data_ok this cycle → COP.
  - COP: icache_req=1 with cop fields. On addr_ok → CWAIT.
  - CWAIT: on data_ok whose head entry is src=1, pulse cop_done → IDLE. The next cop is not accepted before IDLE.
- fetch_addr_ok = icache_addr_ok && icache_req && (state is IDLE or FLOCK).
- Cancel:
  - fetch_cancel=1 sets cancelled=1 on every valid fetch entry.
  - It also sets cancelled=1 on an entry pushed in the same cycle.
  - Cop entries are never cancelled.
- fetch_data_ok = data_ok && head.src==0 && !head.cancelled && !fetch_cancel. A same-cycle cancel drops the response.
- Dropped responses still pop the FIFO.
- Error: data_ok with empty FIFO is ignored and the count stays 0. A simulation assertion fires.
- fetch_cancel does not abort a COP or CWAIT in progress.
- resetn=0 mid-transaction clears all state. Any icache response arriving afterwards is ignored.

Optional Feature:
- Macro: ICACHE_ARB_PERF_EN.
- When defined, adds two ports:
  - perf_fetch_stall  out  32: increments each cycle fetch_req=1 && fetch_addr_ok=0.
  - perf_drop_cnt  out  32: increments per dropped fetch response.
- Both counters wrap at 2^32 and reset to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Back-to-back fetch, addr_ok always 1, data_ok 1 cycle later:
  - fetch_addr_ok every cycle.
  - Count never exceeds 2.
  - fetch_data_ok each cycle, rdata passes through (e.g. 0x24020001).
- MAX_OUTSTANDING=2, data_ok withheld 5 cycles: after 2 accepts icache_req=0; the 3rd accept only after the first data_ok.
- Two fetches in flight, fetch_cancel pulsed, then two data_ok: fetch_data_ok stays 0, FIFO empties, perf_drop_cnt=2 when enabled.
- cop_req with one fetch in flight:
  - DRAIN holds until that fetch's data_ok.
  - COP issues op=1 with the given index/tag.
  - cop_done pulses exactly once, after that request's data_ok.
  - No fetch is granted in between.
- Fetch presented with addr_ok=0 for 3 cycles while cop_req rises: fetch accepted first (FLOCK), then DRAIN → COP.
- resetn low during CWAIT: all outputs 0 next cycle, no cop_done; a stray data_ok afterwards is ignored.
